// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
//   UART_DATA_BITS : data bits per frame
//   START_LVL/STOP_LVL : line levels for the framing bits
//   uart_tx_state_e : transmitter FSM states
package uart_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W      = 3;
  localparam logic        START_LVL      = 1'b0;
  localparam logic        STOP_LVL       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   clk, rst_n      : clock, async active-low reset
//   run_i           : count while high, counter held at 0 while low
//   bit_end_o       : high on the last clk of each bit period
//   bit_pre_end_o   : high on the clk before the last one (lets callers register end-of-bit pulses)
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last        = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_end_o     = run_i && w_last;
  assign bit_pre_end_o = run_i && (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

  // Free-running 0..CLKS_PER_BIT-1 counter while running, wraps at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run_i || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an 8-bit synchronous FIFO and sends them as UART frames, LSB first.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (default build is 8N1).
//   clk, rst_n    : clock, async active-low reset
//   en_i          : permits a new frame to start (never aborts one in flight)
//   fifo_empty_i  : FIFO empty flag
//   fifo_data_i   : FIFO registered data_out, valid the cycle after a pop
//   fifo_rd_en_o  : single-cycle pop per byte
//   txd_o         : serial line, idles high
//   busy_o        : high from FETCH through the last STOP clk
//   byte_done_o   : pulse on the final clk of STOP
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      fifo_empty_i,
  input  logic [UART_DATA_BITS-1:0] fifo_data_i,
  output logic                      fifo_rd_en_o,
  output logic                      txd_o,
  output logic                      busy_o,
  output logic                      byte_done_o
);

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  uart_tx_state_e            r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [BIT_IDX_W-1:0]      r_bit_idx;
  logic                      r_par;
  logic                      w_run;
  logic                      w_bit_end;
  logic                      w_bit_pre_end;
  logic                      w_fetch_ok;

  assign w_run      = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
  assign w_fetch_ok = en_i && !fifo_empty_i;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (w_run),
    .bit_end_o     (w_bit_end),
    .bit_pre_end_o (w_bit_pre_end)
  );

  // Frame sequencer; txd_o is loaded with the level of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_par        <= 1'b0;
      fifo_rd_en_o <= 1'b0;
      txd_o        <= STOP_LVL;
      busy_o       <= 1'b0;
      byte_done_o  <= 1'b0;
    end else begin
      fifo_rd_en_o <= 1'b0;
      byte_done_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fetch_ok) begin
            r_state      <= ST_FETCH;
            fifo_rd_en_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_shift   <= fifo_data_i;
          r_par     <= (^fifo_data_i) ^ PARITY_ODD;
          r_bit_idx <= '0;
          txd_o     <= START_LVL;
          r_state   <= ST_START;
        end
        ST_START: begin
          if (w_bit_end) begin
            txd_o   <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
              if (PARITY_EN) begin
                txd_o   <= r_par;
                r_state <= ST_PARITY;
              end else begin
                txd_o   <= STOP_LVL;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
              r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
              txd_o     <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            txd_o   <= STOP_LVL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Registered pulse lands on the last STOP clk.
          if (w_bit_pre_end) begin
            byte_done_o <= 1'b1;
          end
          if (w_bit_end) begin
            if (w_fetch_ok) begin
              r_state      <= ST_FETCH;
              fifo_rd_en_o <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              busy_o  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          txd_o   <= STOP_LVL;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with a behavioural FIFO model, CLKS_PER_BIT = 4.
module tb_fifo_uart_tx;

  localparam int unsigned CLKS    = 4;
  localparam bit          PAR_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CLKS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_i = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en_o;
  logic       txd_o;
  logic       busy_o;
  logic       byte_done_o;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CLKS),
    .PARITY_ODD   (PAR_ODD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (fifo_rd_en_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .byte_done_o  (byte_done_o)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] sb[$];
  int         start_cycs[$];
  int         stop_cycs[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_empty_err = 0;
  int last_rd_cyc = 0;
  int aborts = 0;
  bit mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    if (expect_tx) sb.push_back(b);
  endtask

  // FIFO model: registered data_out, pop on rd_en.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en_o) begin
      rd_cnt++;
      if (fifo_q.size() == 0) rd_empty_err++;
      else fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en_o) last_rd_cyc = cyc;
  end

  task automatic run_frame();
    logic [31:0] obs;
    logic [31:0] exp_f;
    logic [7:0]  exp_b;
    int stable_bad;
    int busy_bad;
    int done_pos;
    int done_cnt;
    int st;
    bit aborted;
    obs = '0; stable_bad = 0; busy_bad = 0; done_pos = -1; done_cnt = 0; aborted = 1'b0;
    mon_busy = 1'b1;
    st = cyc;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 32'd1, 32'd0);
      exp_b = 8'h00;
    end else begin
      exp_b = sb[0];
    end
    chk("start_latency", 32'(st - last_rd_cyc), 32'd2);
    start_cycs.push_back(st);
    for (int s = 0; s < FRAME_CLKS; s++) begin
      if (s > 0) @(negedge clk);
      if (!rst_n) begin
        aborted = 1'b1;
        break;
      end
      if (s % CLKS == 0) obs[s / CLKS] = txd_o;
      else if (txd_o !== obs[s / CLKS]) stable_bad++;
      if (busy_o !== 1'b1) busy_bad++;
      if (byte_done_o === 1'b1) begin
        done_cnt++;
        done_pos = s;
      end
    end
    if (aborted) begin
      aborts++;
      if (sb.size() > 0) void'(sb.pop_front());
      wait (rst_n);
      mon_busy = 1'b0;
      return;
    end
    exp_f = '0;
    exp_f[8:1] = exp_b;
`ifdef UART_TX_PARITY_EN
    exp_f[9] = (^exp_b) ^ PAR_ODD;
    chk("parity_bit", 32'(obs[9]), 32'((^exp_b) ^ PAR_ODD));
`endif
    exp_f[FRAME_BITS-1] = 1'b1;
    chk("data_byte", 32'(obs[8:1]), 32'(exp_b));
    chk("frame_bits", obs, exp_f);
    chk("bit_width", 32'(stable_bad), 32'd0);
    chk("busy_in_frame", 32'(busy_bad), 32'd0);
    chk("byte_done_pos", 32'(done_pos), 32'(FRAME_CLKS - 1));
    chk("byte_done_cnt", 32'(done_cnt), 32'd1);
    stop_cycs.push_back(cyc);
    if (sb.size() > 0) void'(sb.pop_front());
    mon_busy = 1'b0;
  endtask

  // Line monitor: a low level on an idle line starts a frame.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && txd_o === 1'b0) run_frame();
    end
  end

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    int bad;
    int n;
    en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd_o), 32'd1);
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(byte_done_o), 32'd0);
    rst_n = 1'b1;

    // Empty FIFO with enable: line stays idle.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_o !== 1'b1 || fifo_rd_en_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    chk("idle_empty", 32'(bad), 32'd0);

    // Single byte.
    r0 = rd_cnt;
    push(8'hA5, 1'b1);
    drain("t2", 200);
    chk("t2_pops", 32'(rd_cnt - r0), 32'd1);

    // Back-to-back bytes.
    start_cycs.delete();
    stop_cycs.delete();
    r0 = rd_cnt;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    drain("t3", 400);
    chk("t3_pops", 32'(rd_cnt - r0), 32'd2);
    if (start_cycs.size() == 2 && stop_cycs.size() >= 1)
      chk("t3_gap", 32'(start_cycs[1] - stop_cycs[0]), 32'd3);
    else
      chk("t3_frames", 32'(start_cycs.size()), 32'd2);

    // Disabled with data queued, then enable dropped mid-frame.
    en_i = 1'b0;
    r0 = rd_cnt;
    push(8'h3C, 1'b1);
    push(8'h81, 1'b0);
    push(8'h5A, 1'b0);
    repeat (60) @(negedge clk);
    chk("t4_no_pop_disabled", 32'(rd_cnt - r0), 32'd0);
    en_i = 1'b1;
    n = 0;
    while (!fifo_rd_en_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_rd_wait", 32'(n >= 20), 32'd0);
    repeat (12) @(negedge clk);
    en_i = 1'b0;
    drain("t4", 200);
    repeat (40) @(negedge clk);
    chk("t4_pops", 32'(rd_cnt - r0), 32'd1);
    chk("t4_fifo_left", 32'(fifo_q.size()), 32'd2);

    // Reset during data bit 3 of 0x81.
    sb.push_back(8'h81);
    en_i = 1'b1;
    n = 0;
    while (txd_o !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_wait", 32'(n >= 40), 32'd0);
    repeat (17) @(negedge clk);
    chk("t5_pre_rst_txd", 32'(txd_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_txd_async", 32'(txd_o), 32'd1);
    chk("t5_busy_async", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_fifo_count", 32'(fifo_q.size()), 32'd1);
    chk("t5_aborted", 32'(aborts), 32'd1);
    push(8'h00, 1'b0);
    void'(fifo_q.pop_back());
    sb.push_back(8'h5A);
    rst_n = 1'b1;
    drain("t5", 300);
    chk("t5_fifo_drained", 32'(fifo_q.size()), 32'd0);

    chk("no_pop_when_empty", 32'(rd_empty_err), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
